// File: rtl/dmem_copy_ctrl_if.sv
// Bus bundle for the data-memory copy controller: copy control, core access port
// and the shared single-port data-memory port.
interface dmem_copy_ctrl_if #(
    parameter int AW = 8
);
    logic          Start;
    logic [AW-1:0] SrcAddr;
    logic [AW-1:0] DstAddr;
    logic [AW-1:0] Len;
    logic          Busy;
    logic          Done;
    logic          CoreReq;
    logic          CoreWrite;
    logic [AW-1:0] CoreAddr;
    logic [7:0]    CoreDataIn;
    logic [7:0]    CoreDataOut;
    logic [AW-1:0] MemAddr;
    logic          MemWrite;
    logic [7:0]    MemDataIn;
    logic [7:0]    MemDataOut;

    // Controller view: owns the memory port and the status outputs
    modport master (
        input  Start, SrcAddr, DstAddr, Len,
        input  CoreReq, CoreWrite, CoreAddr, CoreDataIn,
        input  MemDataOut,
        output Busy, Done, CoreDataOut,
        output MemAddr, MemWrite, MemDataIn
    );

    // Environment view: core, copy requester and the memory itself
    modport slave (
        output Start, SrcAddr, DstAddr, Len,
        output CoreReq, CoreWrite, CoreAddr, CoreDataIn,
        output MemDataOut,
        input  Busy, Done, CoreDataOut,
        input  MemAddr, MemWrite, MemDataIn
    );
endinterface

// File: rtl/dmem_copy_ctrl.sv
// Byte-serial DMA copy engine sharing a single-port data memory with a core;
// the core always wins the port and stalls the copy for that cycle.
module dmem_copy_ctrl #(
    parameter int AW = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    dmem_copy_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [AW-1:0] ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] ONE  = {{(AW-1){1'b0}}, 1'b1};

    state_e        state_q, state_d;
    logic [AW-1:0] src_ptr_q, src_ptr_d;
    logic [AW-1:0] dst_ptr_q, dst_ptr_d;
    logic [AW-1:0] count_q, count_d;
    logic [7:0]    buf_q, buf_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [AW-1:0] mem_addr_s;
    logic          mem_write_s;
    logic [7:0]    mem_wdata_s;

    // Next-state and datapath update; a core access freezes the copy in READ/WRITE
    always_comb begin
        state_d   = state_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        count_d   = count_q;
        buf_d     = buf_q;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    if (bus.Len != ZERO) begin
                        src_ptr_d = bus.SrcAddr;
                        dst_ptr_d = bus.DstAddr;
                        count_d   = bus.Len;
                        state_d   = READ;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (!bus.CoreReq) begin
                    buf_d   = bus.MemDataOut;
                    state_d = WRITE;
                end else begin
                    state_d = READ;
                end
            end
            WRITE: begin
                if (!bus.CoreReq) begin
                    // Pointers wrap naturally at 2**AW
                    src_ptr_d = src_ptr_q + ONE;
                    dst_ptr_d = dst_ptr_q + ONE;
                    count_d   = count_q - ONE;
                    state_d   = (count_q > ONE) ? READ : DONE;
                end else begin
                    state_d = WRITE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == READ) || (state_d == WRITE);
        done_d = (state_d == DONE);
    end

    // State and datapath registers
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            src_ptr_q <= ZERO;
            dst_ptr_q <= ZERO;
            count_q   <= ZERO;
            buf_q     <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            count_q   <= count_d;
            buf_q     <= buf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Memory port arbitration: core first, then the active copy phase, else core pass-through
    always_comb begin
        mem_addr_s  = bus.CoreAddr;
        mem_write_s = 1'b0;
        mem_wdata_s = bus.CoreDataIn;
        if (bus.CoreReq) begin
            mem_write_s = bus.CoreWrite;
        end else begin
            case (state_q)
                READ: begin
                    mem_addr_s = src_ptr_q;
                end
                WRITE: begin
                    mem_addr_s  = dst_ptr_q;
                    mem_write_s = 1'b1;
                    mem_wdata_s = buf_q;
                end
                default: begin
                    mem_addr_s = bus.CoreAddr;
                end
            endcase
        end
    end

    assign bus.MemAddr     = mem_addr_s;
    assign bus.MemWrite    = mem_write_s;
    assign bus.MemDataIn   = mem_wdata_s;
    assign bus.CoreDataOut = bus.MemDataOut;
    assign bus.Busy        = busy_q;
    assign bus.Done        = done_q;

endmodule

// File: tb/tb_dmem_copy_ctrl.sv
// Directed bench for dmem_copy_ctrl with a behavioural 256-byte memory; memory
// contents are loaded and inspected through the core port.
module tb_dmem_copy_ctrl;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   busy_n;
    int   done_c;
    int   dma_w;

    logic [7:0] mem [256];

    dmem_copy_ctrl_if #(.AW(8)) bus ();

    dmem_copy_ctrl #(.AW(8)) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.MemWrite) mem[bus.MemAddr] <= bus.MemDataIn;
    end
    assign bus.MemDataOut = mem[bus.MemAddr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_store(input logic [7:0] a, input logic [7:0] d);
        bus.CoreReq    = 1'b1;
        bus.CoreWrite  = 1'b1;
        bus.CoreAddr   = a;
        bus.CoreDataIn = d;
        tick();
        bus.CoreReq    = 1'b0;
        bus.CoreWrite  = 1'b0;
    endtask

    task automatic core_load_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
        bus.CoreReq   = 1'b1;
        bus.CoreWrite = 1'b0;
        bus.CoreAddr  = a;
        #1;
        check(tag, {24'd0, bus.CoreDataOut}, {24'd0, exp});
        bus.CoreReq   = 1'b0;
    endtask

    // Launch a copy and watch it; cycle 1 is the cycle after the accepting edge.
    // Core stores of 55 to address 200 occur in cycles [core_at, core_at+core_n).
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                            input int core_at, input int core_n,
                            output int busy_cnt, output int done_cyc, output int dma_cnt);
        bus.SrcAddr = s;
        bus.DstAddr = d;
        bus.Len     = l;
        bus.Start   = 1'b1;
        tick();
        bus.Start   = 1'b0;
        busy_cnt = 0;
        done_cyc = 0;
        dma_cnt  = 0;
        for (int c = 1; c <= 200; c++) begin
            if (c >= core_at && c < core_at + core_n) begin
                bus.CoreReq    = 1'b1;
                bus.CoreWrite  = 1'b1;
                bus.CoreAddr   = 8'd200;
                bus.CoreDataIn = 8'd55;
            end else begin
                bus.CoreReq   = 1'b0;
                bus.CoreWrite = 1'b0;
            end
            #1;
            if (bus.Busy) busy_cnt++;
            if (bus.MemWrite && !bus.CoreReq) dma_cnt++;
            if (bus.Done) begin
                done_cyc = c;
                break;
            end
            tick();
        end
        bus.CoreReq   = 1'b0;
        bus.CoreWrite = 1'b0;
        tick();
        check("done_single_cycle", {31'd0, bus.Done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        errors         = 0;
        checks         = 0;
        rst            = 1'b1;
        bus.Start      = 1'b0;
        bus.SrcAddr    = 8'd0;
        bus.DstAddr    = 8'd0;
        bus.Len        = 8'd0;
        bus.CoreReq    = 1'b0;
        bus.CoreWrite  = 1'b0;
        bus.CoreAddr   = 8'd0;
        bus.CoreDataIn = 8'd0;
        tick();
        tick();

        // Reset state and core pass-through during reset
        check("rst_busy", {31'd0, bus.Busy}, 32'd0);
        check("rst_done", {31'd0, bus.Done}, 32'd0);
        check("rst_memwrite_idle", {31'd0, bus.MemWrite}, 32'd0);
        bus.CoreReq   = 1'b1;
        bus.CoreWrite = 1'b1;
        bus.CoreAddr  = 8'd7;
        #1;
        check("rst_memwrite_core", {31'd0, bus.MemWrite}, 32'd1);
        check("rst_memaddr_core", {24'd0, bus.MemAddr}, 32'd7);
        bus.CoreReq   = 1'b0;
        bus.CoreWrite = 1'b0;
        #1;
        rst = 1'b0;
        tick();

        // Basic 4-byte copy
        core_store(8'd10, 8'd1);
        core_store(8'd11, 8'd2);
        core_store(8'd12, 8'd3);
        core_store(8'd13, 8'd4);
        run_copy(8'd10, 8'd40, 8'd4, 0, 0, busy_n, done_c, dma_w);
        check("basic_busy_cycles", busy_n, 32'd8);
        check("basic_done_cycle", done_c, 32'd9);
        check("basic_dma_writes", dma_w, 32'd4);
        core_load_check("basic_m40", 8'd40, 8'd1);
        core_load_check("basic_m41", 8'd41, 8'd2);
        core_load_check("basic_m42", 8'd42, 8'd3);
        core_load_check("basic_m43", 8'd43, 8'd4);
        core_load_check("basic_src_kept", 8'd10, 8'd1);

        // Zero-length copy is a bare Done pulse
        run_copy(8'd10, 8'd90, 8'd0, 0, 0, busy_n, done_c, dma_w);
        check("len0_busy_cycles", busy_n, 32'd0);
        check("len0_done_cycle", done_c, 32'd1);
        check("len0_memwrites", dma_w, 32'd0);

        // Source pointer wraps past 255
        core_store(8'd254, 8'd9);
        core_store(8'd255, 8'd8);
        core_store(8'd0, 8'd7);
        core_store(8'd1, 8'd6);
        run_copy(8'd254, 8'd100, 8'd4, 0, 0, busy_n, done_c, dma_w);
        check("wrap_done_cycle", done_c, 32'd9);
        core_load_check("wrap_m100", 8'd100, 8'd9);
        core_load_check("wrap_m101", 8'd101, 8'd8);
        core_load_check("wrap_m102", 8'd102, 8'd7);
        core_load_check("wrap_m103", 8'd103, 8'd6);

        // Core stores for 3 cycles in the middle of a 2-byte copy
        core_store(8'd60, 8'd11);
        core_store(8'd61, 8'd22);
        core_store(8'd200, 8'd0);
        run_copy(8'd60, 8'd80, 8'd2, 2, 3, busy_n, done_c, dma_w);
        check("core_done_cycle", done_c, 32'd8);
        check("core_busy_cycles", busy_n, 32'd7);
        check("core_dma_writes", dma_w, 32'd2);
        core_load_check("core_m80", 8'd80, 8'd11);
        core_load_check("core_m81", 8'd81, 8'd22);
        core_load_check("core_m200", 8'd200, 8'd55);

        // Overlapping forward copy smears the first byte
        core_store(8'd20, 8'd5);
        core_store(8'd21, 8'd6);
        core_store(8'd22, 8'd7);
        run_copy(8'd20, 8'd21, 8'd2, 0, 0, busy_n, done_c, dma_w);
        check("ovl_done_cycle", done_c, 32'd5);
        core_load_check("ovl_m20", 8'd20, 8'd5);
        core_load_check("ovl_m21", 8'd21, 8'd5);
        core_load_check("ovl_m22", 8'd22, 8'd5);

        // Reset in the third cycle of a 4-byte copy aborts it
        core_store(8'd30, 8'hA1);
        core_store(8'd31, 8'hA2);
        core_store(8'd32, 8'hA3);
        core_store(8'd33, 8'hA4);
        for (int i = 0; i < 4; i++) core_store(8'd50 + 8'(i), 8'hEE);
        bus.SrcAddr = 8'd30;
        bus.DstAddr = 8'd50;
        bus.Len     = 8'd4;
        bus.Start   = 1'b1;
        tick();
        bus.Start   = 1'b0;
        tick();
        tick();
        check("abort_busy_before", {31'd0, bus.Busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy_now", {31'd0, bus.Busy}, 32'd0);
        check("abort_memwrite_now", {31'd0, bus.MemWrite}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_done", {31'd0, bus.Done}, 32'd0);
            check("abort_no_busy", {31'd0, bus.Busy}, 32'd0);
        end
        core_load_check("abort_m50", 8'd50, 8'hA1);
        core_load_check("abort_m51", 8'd51, 8'hEE);
        core_load_check("abort_m52", 8'd52, 8'hEE);
        core_load_check("abort_m53", 8'd53, 8'hEE);

        // Normal copy after the abort
        run_copy(8'd30, 8'd50, 8'd4, 0, 0, busy_n, done_c, dma_w);
        check("post_done_cycle", done_c, 32'd9);
        check("post_busy_cycles", busy_n, 32'd8);
        core_load_check("post_m51", 8'd51, 8'hA2);
        core_load_check("post_m53", 8'd53, 8'hA4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
